// File: rtl/ringosc_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized osc_in rising edges
// over a fixed clk gate window and offers the saturated count via valid/ready.
module ringosc_freq_meter #(
    parameter int GATE_CYCLES = 65536,
    parameter int CNT_W       = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             osc_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overflow
);

    localparam int GW = $clog2(GATE_CYCLES + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] GATE = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    localparam logic [GW-1:0]    GATE_LOAD = GW'(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_ONE  = GW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             s0;
    logic             s1;
    logic             s2;
    logic             osc_edge;
    logic [GW-1:0]    gate_cnt;
    logic             gate_last;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_flag;
    logic             ovf_nxt;

    // Three-flop synchronizer for the asynchronous oscillator net; runs always.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s0 <= osc_in;
            s1 <= s0;
            s2 <= s1;
        end
    end

    assign osc_edge  = s1 & ~s2;
    assign gate_last = (gate_cnt == GATE_ONE);

    // Saturating edge count including this cycle's edge; edge at max flags overflow.
    always_comb begin
        cnt_nxt = edge_cnt;
        ovf_nxt = ovf_flag;
        if (osc_edge) begin
            if (edge_cnt == CNT_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = edge_cnt + CNT_ONE;
            end
        end
    end

    // Next-state logic; start is only honoured in IDLE and never queued.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = ARM;
            ARM:  state_nxt = GATE;
            GATE: if (gate_last) state_nxt = HOLD;
            HOLD: if (result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Gate/edge counters: cleared in ARM, advanced in GATE, latched on the last GATE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            if (state == ARM) begin
                gate_cnt <= GATE_LOAD;
                edge_cnt <= '0;
                ovf_flag <= 1'b0;
            end else if (state == GATE) begin
                gate_cnt <= gate_cnt - GATE_ONE;
                edge_cnt <= cnt_nxt;
                ovf_flag <= ovf_nxt;
                if (gate_last) begin
                    result   <= cnt_nxt;
                    overflow <= ovf_nxt;
                end
            end
        end
    end

    assign busy         = (state == ARM) || (state == GATE);
    assign result_valid = (state == HOLD);

endmodule

// File: tb/tb_ringosc_freq_meter.sv
// Directed bench for ringosc_freq_meter: three instances cover nominal,
// saturating and single-cycle-gate configurations.
module tb_ringosc_freq_meter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] ph = 2'd0;

    always #5 clk = ~clk;

    // Free-running phase counter: ph[0] has period 2 clk, ph[1] period 4 clk.
    always @(negedge clk) ph <= ph + 2'd1;

    int checks = 0;
    int errors = 0;

    logic        osc_nom;
    logic        start_nom = 1'b0;
    logic        ready_nom = 1'b0;
    logic        busy_nom;
    logic [23:0] res_nom;
    logic        val_nom;
    logic        ovf_nom;

    logic        osc_sat;
    logic        start_sat = 1'b0;
    logic        ready_sat = 1'b0;
    logic        busy_sat;
    logic [3:0]  res_sat;
    logic        val_sat;
    logic        ovf_sat;

    logic        osc_min = 1'b0;
    logic        start_min = 1'b0;
    logic        ready_min = 1'b0;
    logic        busy_min;
    logic [23:0] res_min;
    logic        val_min;
    logic        ovf_min;

    assign osc_nom = ph[1];
    assign osc_sat = ph[0];

    ringosc_freq_meter #(.GATE_CYCLES(64), .CNT_W(24)) u_nom (
        .clk(clk), .rst(rst), .osc_in(osc_nom), .start(start_nom),
        .busy(busy_nom), .result(res_nom), .result_valid(val_nom),
        .result_ready(ready_nom), .overflow(ovf_nom)
    );

    ringosc_freq_meter #(.GATE_CYCLES(64), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .osc_in(osc_sat), .start(start_sat),
        .busy(busy_sat), .result(res_sat), .result_valid(val_sat),
        .result_ready(ready_sat), .overflow(ovf_sat)
    );

    ringosc_freq_meter #(.GATE_CYCLES(1), .CNT_W(24)) u_min (
        .clk(clk), .rst(rst), .osc_in(osc_min), .start(start_min),
        .busy(busy_min), .result(res_min), .result_valid(val_min),
        .result_ready(ready_min), .overflow(ovf_min)
    );

    task automatic test_reset();
        checks++;
        if (busy_nom !== 1'b0 || val_nom !== 1'b0) begin
            errors++;
            $display("FAIL rst_nom_ctl busy=%b valid=%b want 0 0", busy_nom, val_nom);
        end
        checks++;
        if (res_nom !== 24'd0 || ovf_nom !== 1'b0) begin
            errors++;
            $display("FAIL rst_nom_res result=%0d ovf=%b want 0 0", res_nom, ovf_nom);
        end
        checks++;
        if (busy_sat !== 1'b0 || val_sat !== 1'b0 || res_sat !== 4'd0 || ovf_sat !== 1'b0) begin
            errors++;
            $display("FAIL rst_sat got %b %b %0d %b want 0 0 0 0", busy_sat, val_sat, res_sat, ovf_sat);
        end
        checks++;
        if (busy_min !== 1'b0 || val_min !== 1'b0 || res_min !== 24'd0 || ovf_min !== 1'b0) begin
            errors++;
            $display("FAIL rst_min got %b %b %0d %b want 0 0 0 0", busy_min, val_min, res_min, ovf_min);
        end
    endtask

    task automatic test_nominal();
        int n;
        @(negedge clk);
        start_nom = 1'b1;
        @(negedge clk);
        start_nom = 1'b0;
        n = 0;
        while (busy_nom === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 65) begin
            errors++;
            $display("FAIL nom_busy_len got %0d want 65", n);
        end
        checks++;
        if (val_nom !== 1'b1 || res_nom !== 24'd16 || ovf_nom !== 1'b0) begin
            errors++;
            $display("FAIL nom_result got v=%b r=%0d o=%b want 1 16 0", val_nom, res_nom, ovf_nom);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (val_nom !== 1'b1) begin
            errors++;
            $display("FAIL nom_valid_hold got %b want 1", val_nom);
        end
        ready_nom = 1'b1;
        @(negedge clk);
        ready_nom = 1'b0;
        checks++;
        if (val_nom !== 1'b0) begin
            errors++;
            $display("FAIL nom_valid_drop got %b want 0", val_nom);
        end
    endtask

    task automatic test_saturation();
        int n;
        @(negedge clk);
        start_sat = 1'b1;
        @(negedge clk);
        start_sat = 1'b0;
        n = 0;
        while (busy_sat === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 65) begin
            errors++;
            $display("FAIL sat_busy_len got %0d want 65", n);
        end
        checks++;
        if (val_sat !== 1'b1 || res_sat !== 4'd15 || ovf_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_result got v=%b r=%0d o=%b want 1 15 1", val_sat, res_sat, ovf_sat);
        end
        ready_sat = 1'b1;
        @(negedge clk);
        ready_sat = 1'b0;
        checks++;
        if (val_sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_valid_drop got %b want 0", val_sat);
        end
    endtask

    task automatic test_ignored_start();
        int n;
        @(negedge clk);
        start_nom = 1'b1;
        @(negedge clk);
        start_nom = 1'b0;
        n = 0;
        while (busy_nom === 1'b1 && n < 200) begin
            n++;
            start_nom = (n == 10);
            @(negedge clk);
        end
        start_nom = 1'b0;
        checks++;
        if (n !== 65) begin
            errors++;
            $display("FAIL ign_busy_len got %0d want 65", n);
        end
        start_nom = 1'b1;
        ready_nom = 1'b1;
        @(negedge clk);
        start_nom = 1'b0;
        ready_nom = 1'b0;
        checks++;
        if (val_nom !== 1'b0 || busy_nom !== 1'b0) begin
            errors++;
            $display("FAIL ign_hold_start got v=%b busy=%b want 0 0", val_nom, busy_nom);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (val_nom !== 1'b0 || busy_nom !== 1'b0) begin
            errors++;
            $display("FAIL ign_no_second got v=%b busy=%b want 0 0", val_nom, busy_nom);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        @(negedge clk);
        start_nom = 1'b1;
        @(negedge clk);
        start_nom = 1'b0;
        n = 0;
        while (busy_nom === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 65) begin
            errors++;
            $display("FAIL bp_busy_len got %0d want 65", n);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (val_nom !== 1'b1 || res_nom !== 24'd16) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_stable unstable_cycles=%0d want 0", bad);
        end
        ready_nom = 1'b1;
        @(negedge clk);
        ready_nom = 1'b0;
        checks++;
        if (val_nom !== 1'b0 || res_nom !== 24'd16) begin
            errors++;
            $display("FAIL bp_transfer got v=%b r=%0d want 0 16", val_nom, res_nom);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        start_nom = 1'b1;
        @(negedge clk);
        start_nom = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (busy_nom !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pre_busy got %b want 1", busy_nom);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy_nom !== 1'b0 || val_nom !== 1'b0 || res_nom !== 24'd0 || ovf_nom !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async got %b %b %0d %b want 0 0 0 0", busy_nom, val_nom, res_nom, ovf_nom);
        end
        checks++;
        if (res_sat !== 4'd0 || ovf_sat !== 1'b0) begin
            errors++;
            $display("FAIL rmid_sat_clear got r=%0d o=%b want 0 0", res_sat, ovf_sat);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_nom = 1'b1;
        @(negedge clk);
        start_nom = 1'b0;
        n = 0;
        while (busy_nom === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 65 || val_nom !== 1'b1 || res_nom !== 24'd16) begin
            errors++;
            $display("FAIL rmid_fresh got len=%0d v=%b r=%0d want 65 1 16", n, val_nom, res_nom);
        end
        ready_nom = 1'b1;
        @(negedge clk);
        ready_nom = 1'b0;
    endtask

    task automatic test_min_gate();
        int n;
        @(negedge clk);
        start_min = 1'b1;
        @(negedge clk);
        start_min = 1'b0;
        n = 0;
        while (busy_min === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL min_busy_len got %0d want 2", n);
        end
        checks++;
        if (val_min !== 1'b1 || res_min !== 24'd0 || ovf_min !== 1'b0) begin
            errors++;
            $display("FAIL min_zero got v=%b r=%0d o=%b want 1 0 0", val_min, res_min, ovf_min);
        end
        ready_min = 1'b1;
        @(negedge clk);
        ready_min = 1'b0;
        @(negedge clk);
        start_min = 1'b1;
        osc_min = 1'b1;
        @(negedge clk);
        start_min = 1'b0;
        n = 0;
        while (busy_min === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL min_edge_busy got %0d want 2", n);
        end
        checks++;
        if (val_min !== 1'b1 || res_min !== 24'd1) begin
            errors++;
            $display("FAIL min_edge got v=%b r=%0d want 1 1", val_min, res_min);
        end
        ready_min = 1'b1;
        @(negedge clk);
        ready_min = 1'b0;
        osc_min = 1'b0;
        checks++;
        if (val_min !== 1'b0) begin
            errors++;
            $display("FAIL min_valid_drop got %b want 0", val_min);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_nominal();
        test_saturation();
        test_ignored_start();
        test_backpressure();
        test_reset_mid();
        test_min_gate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
